collision_judge: RTL and testbench

- Consumes the per-pixel sprite masks produced while the VGA scan walks the active area: enemy_en from the enemy plane block, and the bullet and player masks.
- Decides once per frame whether a bullet hit the enemy or the enemy crashed into the player.
- Generates the boom pulse back to the enemy block, latches the explosion position, runs the explosion cooldown, and keeps BCD score and lives.
- Sits between the sprite renderers and the score/HUD logic.

---
 rtl/game_pkg.sv | 18 +
 rtl/bcd_counter4.sv | 47 ++++
 rtl/collision_judge.sv | 161 ++++++++++++++++
 tb/tb_collision_judge.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared types and constants for the collision/score path of the shooter game.
package game_pkg;

    localparam int H_ACTIVE_DEF   = 640;
    localparam int V_ACTIVE_DEF   = 480;
    localparam int SPRITE_SIZE    = 50;
    localparam int SCREEN_W_LIMIT = 590;

    localparam int BCD_DIGIT_W = 4;
    localparam int BCD_DIGITS  = 4;

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_EXPLODE   = 2'd1,
        ST_GAME_OVER = 2'd2
    } state_e;

endpackage

// File: rtl/bcd_counter4.sv
// Four-digit BCD up-counter with synchronous clear; 9999 rolls over to 0000.
module bcd_counter4
    import game_pkg::*;
(
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              clr,
    input  logic                              inc,
    output logic [BCD_DIGITS*BCD_DIGIT_W-1:0] count
);

    localparam int W = BCD_DIGITS * BCD_DIGIT_W;

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;
    logic         carry;

    always_comb begin
        count_d = count_q;
        carry   = inc;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (carry) begin
                if (count_q[i*BCD_DIGIT_W +: BCD_DIGIT_W] == BCD_DIGIT_W'(9)) begin
                    count_d[i*BCD_DIGIT_W +: BCD_DIGIT_W] = '0;
                end else begin
                    count_d[i*BCD_DIGIT_W +: BCD_DIGIT_W] =
                        count_q[i*BCD_DIGIT_W +: BCD_DIGIT_W] + BCD_DIGIT_W'(1);
                    carry = 1'b0;
                end
            end
        end
        if (clr) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/collision_judge.sv
// Per-frame hit/crash judge: accumulates sprite overlaps over the active area,
// then drives boom, explosion cooldown, BCD score and lives at each frame end.
//
//   state        | meaning
//   ST_RUN       | normal play, overlaps are judged at frame end
//   ST_EXPLODE   | enemy exploding, player invulnerable for EXPLODE_FRAMES frames
//   ST_GAME_OVER | no lives left, score frozen until restart
module collision_judge
    import game_pkg::*;
#(
    parameter int H_ACTIVE       = H_ACTIVE_DEF,
    parameter int V_ACTIVE       = V_ACTIVE_DEF,
    parameter int EXPLODE_FRAMES = 16,
    parameter int INIT_LIVES     = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    input  logic        enemy_en,
    input  logic        bullet_en,
    input  logic        player_en,
    input  logic [9:0]  enemy_x,
    input  logic [9:0]  enemy_y,
    input  logic        restart,
    output logic        boom,
    output logic        explode_active,
    output logic [9:0]  explode_x,
    output logic [9:0]  explode_y,
    output logic [15:0] score,
    output logic [3:0]  lives,
    output logic        game_over
);

    localparam logic [9:0] X_END      = 10'(H_ACTIVE);
    localparam logic [9:0] Y_END      = 10'(V_ACTIVE);
    localparam logic [9:0] X_LAST     = 10'(H_ACTIVE - 1);
    localparam logic [9:0] Y_LAST     = 10'(V_ACTIVE - 1);
    localparam logic [7:0] CNT_LAST   = 8'(EXPLODE_FRAMES - 1);
    localparam logic [3:0] LIVES_INIT = 4'(INIT_LIVES);

    state_e     state_q, state_d;
    logic       hit_q, hit_d;
    logic       crash_q, crash_d;
    logic       at_last_q, at_last_d;
    logic [7:0] frame_cnt_q, frame_cnt_d;
    logic       boom_q, boom_d;
    logic [9:0] ex_x_q, ex_x_d;
    logic [9:0] ex_y_q, ex_y_d;
    logic [3:0] lives_q, lives_d;

    logic active, at_last, frame_end;
    logic hit_now, crash_now, eff_hit, eff_crash;
    logic score_inc;

    assign active    = (x < X_END) && (y < Y_END);
    assign at_last   = (x == X_LAST) && (y == Y_LAST);
    // A last pixel held for several clocks must be judged only once.
    assign frame_end = at_last & ~at_last_q;
    assign hit_now   = active & enemy_en & bullet_en;
    assign crash_now = active & enemy_en & player_en;
    assign eff_hit   = hit_q | hit_now;
    assign eff_crash = crash_q | crash_now;

    always_comb begin
        state_d     = state_q;
        hit_d       = hit_q | hit_now;
        crash_d     = crash_q | crash_now;
        at_last_d   = at_last;
        frame_cnt_d = frame_cnt_q;
        boom_d      = 1'b0;
        ex_x_d      = ex_x_q;
        ex_y_d      = ex_y_q;
        lives_d     = lives_q;
        score_inc   = 1'b0;

        if (restart) begin
            state_d     = ST_RUN;
            hit_d       = 1'b0;
            crash_d     = 1'b0;
            frame_cnt_d = '0;
            lives_d     = LIVES_INIT;
        end else if (frame_end) begin
            hit_d   = 1'b0;
            crash_d = 1'b0;
            unique case (state_q)
                ST_RUN: begin
                    if (eff_hit) begin
                        boom_d      = 1'b1;
                        ex_x_d      = enemy_x;
                        ex_y_d      = enemy_y;
                        score_inc   = 1'b1;
                        frame_cnt_d = '0;
                        state_d     = ST_EXPLODE;
                    end
                    // Losing the last life overrides the explosion transition.
                    if (eff_crash && (lives_q != 4'd0)) begin
                        lives_d = lives_q - 4'd1;
                        if (lives_q == 4'd1) begin
                            state_d = ST_GAME_OVER;
                        end
                    end
                end
                ST_EXPLODE: begin
                    if (frame_cnt_q == CNT_LAST) begin
                        frame_cnt_d = '0;
                        state_d     = ST_RUN;
                    end else begin
                        frame_cnt_d = frame_cnt_q + 8'd1;
                    end
                end
                ST_GAME_OVER: begin
                    state_d = ST_GAME_OVER;
                end
                default: begin
                    state_d = ST_RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            hit_q       <= 1'b0;
            crash_q     <= 1'b0;
            at_last_q   <= 1'b0;
            frame_cnt_q <= '0;
            boom_q      <= 1'b0;
            ex_x_q      <= '0;
            ex_y_q      <= '0;
            lives_q     <= LIVES_INIT;
        end else begin
            state_q     <= state_d;
            hit_q       <= hit_d;
            crash_q     <= crash_d;
            at_last_q   <= at_last_d;
            frame_cnt_q <= frame_cnt_d;
            boom_q      <= boom_d;
            ex_x_q      <= ex_x_d;
            ex_y_q      <= ex_y_d;
            lives_q     <= lives_d;
        end
    end

    bcd_counter4 u_score (
        .clk   (clk),
        .rst   (rst),
        .clr   (restart),
        .inc   (score_inc),
        .count (score)
    );

    assign boom           = boom_q;
    assign explode_active = (state_q == ST_EXPLODE);
    assign explode_x      = ex_x_q;
    assign explode_y      = ex_y_q;
    assign lives          = lives_q;
    assign game_over      = (state_q == ST_GAME_OVER);

endmodule

// File: tb/tb_collision_judge.sv
// Bench for collision_judge: frame-level vector table, hand-written corner
// sequences, random frames against a frame-level model, and BCD wrap on a
// second instance with a one-frame cooldown.
module tb_collision_judge;

    localparam int EF     = 16;
    localparam int INIT_L = 3;
    localparam int M_RUN  = 0;
    localparam int M_EXP  = 1;
    localparam int M_OVER = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [9:0]  x, y, enemy_x, enemy_y;
    logic        enemy_en, bullet_en, player_en, restart;
    logic        boom, explode_active, game_over;
    logic [9:0]  explode_x, explode_y;
    logic [15:0] score;
    logic [3:0]  lives;

    collision_judge #(.EXPLODE_FRAMES(EF), .INIT_LIVES(INIT_L)) dut (
        .clk(clk), .rst(rst), .x(x), .y(y),
        .enemy_en(enemy_en), .bullet_en(bullet_en), .player_en(player_en),
        .enemy_x(enemy_x), .enemy_y(enemy_y), .restart(restart),
        .boom(boom), .explode_active(explode_active),
        .explode_x(explode_x), .explode_y(explode_y),
        .score(score), .lives(lives), .game_over(game_over)
    );

    logic [9:0]  fx, fy;
    logic        fe, fb;
    logic        f_boom, f_ea, f_go;
    logic [9:0]  f_ex_x, f_ex_y;
    logic [15:0] f_score;
    logic [3:0]  f_lives;

    collision_judge #(.EXPLODE_FRAMES(1), .INIT_LIVES(INIT_L)) u_fast (
        .clk(clk), .rst(rst), .x(fx), .y(fy),
        .enemy_en(fe), .bullet_en(fb), .player_en(1'b0),
        .enemy_x(10'd5), .enemy_y(10'd7), .restart(1'b0),
        .boom(f_boom), .explode_active(f_ea),
        .explode_x(f_ex_x), .explode_y(f_ex_y),
        .score(f_score), .lives(f_lives), .game_over(f_go)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    task automatic cyc(input int xv, input int yv, input logic e, input logic b,
                       input logic p, input logic r);
        x = 10'(xv); y = 10'(yv);
        enemy_en = e; bullet_en = b; player_en = p; restart = r;
        @(posedge clk); #1;
    endtask

    // Inactive-area coincidences surround the one active pixel and must be ignored.
    task automatic play_frame(input logic h, input logic c);
        cyc(645, 200, 1, 1, 1, 0);
        cyc(100, 200, 1, h, c, 0);
        cyc(100, 485, 1, 1, 1, 0);
        cyc(639, 479, 0, 0, 0, 0);
    endtask

    typedef struct {
        logic        hit;
        logic        crash;
        logic        boom;
        logic [15:0] score;
        logic [3:0]  lives;
        logic        go;
        logic        ea;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic h, input logic c, input logic bm, input logic [15:0] sc,
                       input logic [3:0] lv, input logic go, input logic ea, input int n);
        vec_t v;
        v.hit = h; v.crash = c; v.boom = bm; v.score = sc; v.lives = lv; v.go = go; v.ea = ea;
        for (int i = 0; i < n; i++) tbl.push_back(v);
    endtask

    int m_score, m_lives, m_mode, m_left;

    task automatic rand_frame();
        int n, px, py;
        logic e, b, p, fh, fc, exp_boom;
        fh = 1'b0; fc = 1'b0; exp_boom = 1'b0;
        if ($urandom_range(0, 19) == 0) begin
            cyc(0, 0, 0, 0, 0, 1);
            m_score = 0; m_lives = INIT_L; m_mode = M_RUN; m_left = 0;
            chk("rnd_restart_score", 32'(score), 32'(to_bcd(m_score)));
            chk("rnd_restart_lives", 32'(lives), 32'(m_lives));
        end
        n = $urandom_range(1, 4);
        for (int k = 0; k < n; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                if ($urandom_range(0, 1) == 0) begin
                    px = $urandom_range(640, 1023); py = $urandom_range(0, 1023);
                end else begin
                    px = $urandom_range(0, 1023); py = $urandom_range(480, 1023);
                end
            end else begin
                px = $urandom_range(0, 639); py = $urandom_range(0, 479);
            end
            if (px == 639 && py == 479) px = 638;
            e = 1'($urandom_range(0, 1));
            b = ($urandom_range(0, 3) == 0);
            p = ($urandom_range(0, 5) == 0);
            cyc(px, py, e, b, p, 0);
            if (px < 640 && py < 480) begin
                fh |= e & b;
                fc |= e & p;
            end
        end
        e = 1'($urandom_range(0, 1));
        b = ($urandom_range(0, 3) == 0);
        p = ($urandom_range(0, 7) == 0);
        enemy_x = 10'($urandom_range(0, 589));
        enemy_y = 10'($urandom_range(0, 429));
        cyc(639, 479, e, b, p, 0);
        fh |= e & b;
        fc |= e & p;

        if (m_mode == M_RUN) begin
            if (fh) begin
                exp_boom = 1'b1;
                m_score  = (m_score + 1) % 10000;
                m_mode   = M_EXP;
                m_left   = EF;
            end
            if (fc && m_lives > 0) begin
                m_lives--;
                if (m_lives == 0) m_mode = M_OVER;
            end
        end else if (m_mode == M_EXP) begin
            m_left--;
            if (m_left == 0) m_mode = M_RUN;
        end

        chk("rnd_boom", 32'(boom), 32'(exp_boom));
        chk("rnd_score", 32'(score), 32'(to_bcd(m_score)));
        chk("rnd_lives", 32'(lives), 32'(m_lives));
        chk("rnd_game_over", 32'(game_over), 32'(m_mode == M_OVER));
        chk("rnd_explode_active", 32'(explode_active), 32'(m_mode == M_EXP));
        if (exp_boom) begin
            chk("rnd_explode_x", 32'(explode_x), 32'(enemy_x));
            chk("rnd_explode_y", 32'(explode_y), 32'(enemy_y));
        end
    endtask

    initial begin
        int booms;
        rst = 1'b1; x = '0; y = '0; enemy_en = 0; bullet_en = 0; player_en = 0;
        restart = 0; enemy_x = '0; enemy_y = '0;
        fx = '0; fy = '0; fe = 0; fb = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_score", 32'(score), 32'h0);
        chk("reset_lives", 32'(lives), 32'(INIT_L));
        chk("reset_boom", 32'(boom), 32'h0);
        chk("reset_game_over", 32'(game_over), 32'h0);
        chk("reset_explode_active", 32'(explode_active), 32'h0);
        chk("reset_explode_xy", 32'({explode_x, explode_y}), 32'h0);
        rst = 1'b0;

        // Frame-level expectations: idle, hit, cooldown with repeated hits, crashes, game over.
        add(0, 0, 0, 16'h0000, 3, 0, 0, 2);
        add(1, 0, 1, 16'h0001, 3, 0, 1, 1);
        add(1, 0, 0, 16'h0001, 3, 0, 1, EF - 1);
        add(1, 0, 0, 16'h0001, 3, 0, 0, 1);
        add(1, 0, 1, 16'h0002, 3, 0, 1, 1);
        add(0, 0, 0, 16'h0002, 3, 0, 1, EF - 1);
        add(0, 0, 0, 16'h0002, 3, 0, 0, 1);
        add(0, 1, 0, 16'h0002, 2, 0, 0, 1);
        add(0, 1, 0, 16'h0002, 1, 0, 0, 1);
        add(0, 1, 0, 16'h0002, 0, 1, 0, 1);
        add(1, 0, 0, 16'h0002, 0, 1, 0, 2);
        add(1, 1, 0, 16'h0002, 0, 1, 0, 1);

        enemy_x = 10'd120; enemy_y = 10'd60;
        foreach (tbl[i]) begin
            play_frame(tbl[i].hit, tbl[i].crash);
            chk($sformatf("tbl%0d_boom", i), 32'(boom), 32'(tbl[i].boom));
            chk($sformatf("tbl%0d_score", i), 32'(score), 32'(tbl[i].score));
            chk($sformatf("tbl%0d_lives", i), 32'(lives), 32'(tbl[i].lives));
            chk($sformatf("tbl%0d_game_over", i), 32'(game_over), 32'(tbl[i].go));
            chk($sformatf("tbl%0d_explode_active", i), 32'(explode_active), 32'(tbl[i].ea));
            if (tbl[i].boom) begin
                chk($sformatf("tbl%0d_explode_xy", i), 32'({explode_x, explode_y}), {12'h0, 10'd120, 10'd60});
            end
            cyc(0, 0, 0, 0, 0, 0);
            chk($sformatf("tbl%0d_boom_drop", i), 32'(boom), 32'h0);
        end

        // Restart out of game over.
        cyc(0, 0, 0, 0, 0, 1);
        chk("restart_score", 32'(score), 32'h0);
        chk("restart_lives", 32'(lives), 32'(INIT_L));
        chk("restart_game_over", 32'(game_over), 32'h0);

        // Last pixel held for 4 clocks: a single evaluation.
        enemy_x = 10'd300; enemy_y = 10'd400;
        cyc(100, 200, 1, 1, 0, 0);
        booms = 0;
        for (int k = 0; k < 4; k++) begin
            cyc(639, 479, 0, 0, 0, 0);
            booms += int'(boom);
            if (k == 0) chk("hold_boom_first", 32'(boom), 32'h1);
        end
        chk("hold_boom_count", 32'(booms), 32'd1);
        chk("hold_score", 32'(score), 32'h0001);
        chk("hold_explode_x", 32'(explode_x), 32'd300);

        // Restart on the frame_end cycle with a pending hit wins over evaluation.
        enemy_x = 10'd11; enemy_y = 10'd22;
        cyc(100, 200, 1, 1, 0, 0);
        booms = 0;
        for (int k = 0; k < 4; k++) begin
            cyc(639, 479, k == 0, k == 0, 1'b0, k == 0);
            booms += int'(boom);
        end
        chk("rsfe_boom_count", 32'(booms), 32'd0);
        chk("rsfe_score", 32'(score), 32'h0);
        chk("rsfe_lives", 32'(lives), 32'(INIT_L));
        chk("rsfe_explode_active", 32'(explode_active), 32'h0);
        chk("rsfe_explode_kept", 32'({explode_x, explode_y}), {12'h0, 10'd300, 10'd400});

        m_score = 0; m_lives = INIT_L; m_mode = M_RUN; m_left = 0;
        for (int f = 0; f < 300; f++) rand_frame();

        // BCD wrap on the fast-cooldown instance: 9999 hits, then one more.
        for (int i = 0; i < 9999; i++) begin
            fx = '0; fy = '0; fe = 0; fb = 0;
            @(posedge clk); #1;
            fx = 10'd639; fy = 10'd479; fe = 1; fb = 1;
            @(posedge clk); #1;
            fx = '0; fy = '0; fe = 0; fb = 0;
            @(posedge clk); #1;
            fx = 10'd639; fy = 10'd479;
            @(posedge clk); #1;
        end
        chk("wrap_pre_score", 32'(f_score), 32'h9999);
        chk("wrap_pre_explode_active", 32'(f_ea), 32'h0);
        fx = '0; fy = '0;
        @(posedge clk); #1;
        fx = 10'd639; fy = 10'd479; fe = 1; fb = 1;
        @(posedge clk); #1;
        chk("wrap_boom", 32'(f_boom), 32'h1);
        chk("wrap_score", 32'(f_score), 32'h0000);
        chk("wrap_lives", 32'(f_lives), 32'(INIT_L));
        chk("wrap_game_over", 32'(f_go), 32'h0);
        chk("wrap_explode_xy", 32'({f_ex_x, f_ex_y}), {12'h0, 10'd5, 10'd7});

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
